uart_tx: RTL and testbench

- DZ11 UART transmitter; sits directly downstream of the baud rate generator and consumes its 16x clock enable (brgCLKEN).
- Accepts one character from the DZ11 transmit buffer logic and serializes it onto txd.
- Frame format: start bit, 5–8 data bits LSB first, optional parity, then 1 or 2 stop bits.
- Character format is set by the DZ11 line parameter fields.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_tx_if.sv | 29 ++
 rtl/uart_tx.sv | 115 +++++++++++
 tb/tb_uart_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the DZ11 UART transmitter: character-length codes,
// FSM state encoding and the oversample factor shared with the baud generator.
package uart_pkg;

    localparam int CLKDIV = 16;

    localparam logic [1:0] LEN5 = 2'b00;
    localparam logic [1:0] LEN6 = 2'b01;
    localparam logic [1:0] LEN7 = 2'b10;
    localparam logic [1:0] LEN8 = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    // Index of the last data bit sent for a given length code.
    function automatic logic [2:0] last_index(input logic [1:0] len);
        case (len)
            LEN5:    return 3'd4;
            LEN6:    return 3'd5;
            LEN7:    return 3'd6;
            LEN8:    return 3'd7;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] len,
                                        input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) <= last_index(len)) p = p ^ d[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Character/format/handshake bundle between the DZ11 transmit buffer logic
// (master) and the UART transmitter (slave).
interface uart_tx_if;
    import uart_pkg::*;

    // load is a one-cycle strobe; it is taken only in a cycle where empty=1
    // and is silently dropped otherwise. done pulses once per completed frame.
    logic [7:0] data;
    logic [1:0] length;
    logic       parity;
    logic       parodd;
    logic       stop;
    logic       load;
    logic       empty;
    logic       done;
    logic       txd;
    state_t     state;

    modport master (
        output data, length, parity, parodd, stop, load,
        input  empty, done, txd, state
    );

    modport slave (
        input  data, length, parity, parodd, stop, load,
        output empty, done, txd, state
    );

endinterface

// File: rtl/uart_tx.sv
// DZ11 UART transmitter: serializes one latched character as start, 5-8 data
// bits LSB first, optional parity and 1-2 stop bits, paced by the 16x enable.
module uart_tx
    import uart_pkg::*;
#(
    parameter int clkdiv = CLKDIV
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      clr,
    input  logic      brgCLKEN,
    uart_tx_if.slave  bus
);

    localparam logic [3:0] TICK_LAST = 4'(clkdiv - 1);

    state_t     state_q;
    logic [3:0] tick_q;
    logic [2:0] idx_q;
    logic [7:0] shreg_q;
    logic [1:0] len_q;
    logic       par_q;
    logic       parbit_q;
    logic       stop_q;
    logic       txd_q;
    logic       empty_q;
    logic       done_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q  <= IDLE;
            tick_q   <= 4'd0;
            idx_q    <= 3'd0;
            shreg_q  <= 8'd0;
            len_q    <= LEN5;
            par_q    <= 1'b0;
            parbit_q <= 1'b0;
            stop_q   <= 1'b0;
            txd_q    <= 1'b1;
            empty_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                // An enable coinciding with load is deliberately not counted.
                if (bus.load) begin
                    shreg_q  <= bus.data;
                    len_q    <= bus.length;
                    par_q    <= bus.parity;
                    parbit_q <= parity_bit(bus.data, bus.length, bus.parodd);
                    stop_q   <= bus.stop;
                    tick_q   <= 4'd0;
                    state_q  <= START;
                    txd_q    <= 1'b0;
                    empty_q  <= 1'b0;
                end
            end else if (brgCLKEN) begin
                if (tick_q != TICK_LAST) begin
                    tick_q <= tick_q + 4'd1;
                end else begin
                    tick_q <= 4'd0;
                    case (state_q)
                        START: begin
                            state_q <= DATA;
                            idx_q   <= 3'd0;
                            txd_q   <= shreg_q[0];
                            shreg_q <= shreg_q >> 1;
                        end
                        DATA: begin
                            if (idx_q == last_index(len_q)) begin
                                state_q <= par_q ? PARITY : STOP1;
                                txd_q   <= par_q ? parbit_q : 1'b1;
                            end else begin
                                idx_q   <= idx_q + 3'd1;
                                txd_q   <= shreg_q[0];
                                shreg_q <= shreg_q >> 1;
                            end
                        end
                        PARITY: begin
                            state_q <= STOP1;
                            txd_q   <= 1'b1;
                        end
                        STOP1: begin
                            txd_q <= 1'b1;
                            if (stop_q) begin
                                state_q <= STOP2;
                            end else begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                                empty_q <= 1'b1;
                            end
                        end
                        STOP2: begin
                            state_q <= IDLE;
                            txd_q   <= 1'b1;
                            done_q  <= 1'b1;
                            empty_q <= 1'b1;
                        end
                        default: begin
                            state_q <= IDLE;
                            txd_q   <= 1'b1;
                            empty_q <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.txd   = txd_q;
    assign bus.empty = empty_q;
    assign bus.done  = done_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frame table, busy/back-to-back/
// reset sequences, and randomized frames against a bit-list reference model.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int W = 1;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  len;
        logic        par;
        logic        odd;
        logic        stp;
        int          period;
        int          nbits;
        logic [11:0] bits;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic brg_clken = 1'b0;

    uart_tx_if bus ();

    uart_tx #(.clkdiv(CLKDIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .brgCLKEN (brg_clken),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the frame as an ordered list of line levels, one per bit time.
    function automatic void build_frame(input logic [7:0] d, input logic [1:0] len,
                                        input logic par, input logic odd, input logic stp);
        int nd;
        int ones;
        nd = 5 + int'(len);
        ones = 0;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < nd; i++) begin
            exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par) exp_q.push_back(((ones % 2) == 1) ? ~odd : odd);
        exp_q.push_back(1'b1);
        if (stp) exp_q.push_back(1'b1);
    endfunction

    function automatic void table_frame(input vec_t v);
        exp_q.delete();
        for (int i = 0; i < v.nbits; i++) exp_q.push_back(v.bits[i]);
    endfunction

    task automatic drive_load(input vec_t v);
        bus.data   = v.data;
        bus.length = v.len;
        bus.parity = v.par;
        bus.parodd = v.odd;
        bus.stop   = v.stp;
        bus.load   = 1'b1;
    endtask

    task automatic scramble_format();
        bus.data   = 8'($urandom);
        bus.length = 2'($urandom);
        bus.parity = 1'($urandom);
        bus.parodd = 1'($urandom);
        bus.stop   = 1'($urandom);
    endtask

    task automatic do_reset(input logic use_clr);
        bus.load  = 1'b0;
        brg_clken = 1'b0;
        if (use_clr) clr = 1'b1; else rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clr = 1'b0;
    endtask

    // Sends (or continues, when chained) the frame in exp_q and follows it
    // enable by enable; expected level is exp_q[enables_seen / CLKDIV].
    task automatic run_frame(input vec_t v, input logic chained, input int busy_at,
                             input int abort_n, input logic chain_next, input vec_t nv);
        int n;
        int cyc;
        int total;
        int err0;
        n = 0;
        cyc = 1;
        total = exp_q.size() * CLKDIV;
        err0 = errors;
        if (!chained) begin
            check("empty_before_load", 32'(bus.empty), 32'd1);
            drive_load(v);
            brg_clken = (v.period == 1);
        end
        @(posedge clk); #1;
        bus.load = 1'b0;
        scramble_format();
        while (1) begin
            if (n == abort_n) return;
            if (n == total) begin
                check("done_pulse", 32'(bus.done), 32'd1);
                check("empty_at_done", 32'(bus.empty), 32'd1);
                check("txd_at_done", 32'(bus.txd), 32'd1);
                if (chain_next) begin
                    drive_load(nv);
                    brg_clken = 1'b1;
                end else begin
                    brg_clken = 1'b0;
                    @(posedge clk); #1;
                    check("done_one_cycle", 32'(bus.done), 32'd0);
                    check("empty_after_frame", 32'(bus.empty), 32'd1);
                    check("txd_idle_after", 32'(bus.txd), 32'd1);
                end
                return;
            end
            check($sformatf("txd_bit%0d", n / CLKDIV), 32'(bus.txd), 32'(exp_q[n / CLKDIV]));
            check("done_low_in_frame", 32'(bus.done), 32'd0);
            check("empty_low_in_frame", 32'(bus.empty), 32'd0);
            if (errors != err0) return;
            if (cyc == busy_at) begin
                bus.data = 8'h41;
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            brg_clken = ((cyc % v.period) == (v.period - 1));
            @(posedge clk); #1;
            if (brg_clken) n++;
            cyc++;
        end
    endtask

    initial begin
        vec_t rv;
        int seen_done;
        bus.data = 8'd0; bus.length = 2'd0; bus.parity = 1'b0;
        bus.parodd = 1'b0; bus.stop = 1'b0; bus.load = 1'b0;

        tbl[0] = '{8'h55, LEN8, 1'b0, 1'b0, 1'b0, 1,  10, 12'h2AA}; // 8N1
        tbl[1] = '{8'hFF, LEN7, 1'b1, 1'b0, 1'b0, 1,  10, 12'h3FE}; // 7E1, bit 7 ignored
        tbl[2] = '{8'hFF, LEN7, 1'b1, 1'b1, 1'b0, 2,  10, 12'h2FE}; // 7O1
        tbl[3] = '{8'hE3, LEN5, 1'b1, 1'b1, 1'b1, 1,  9,  12'h1C6}; // 5O2
        tbl[4] = '{8'h55, LEN8, 1'b0, 1'b0, 1'b0, 27, 10, 12'h2AA}; // BRG pacing
        tbl[5] = '{8'h2D, LEN6, 1'b1, 1'b0, 1'b1, 3,  10, 12'h35A}; // 6E2

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_txd", 32'(bus.txd), 32'd1);
        check("reset_empty", 32'(bus.empty), 32'd1);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_state", 32'(bus.state), 32'(IDLE));

        // Reset and load together: reset wins
        drive_load(tbl[0]);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vs_load_empty", 32'(bus.empty), 32'd1);
        check("rst_vs_load_txd", 32'(bus.txd), 32'd1);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            table_frame(tbl[i]);
            run_frame(tbl[i], 1'b0, -1, -1, 1'b0, tbl[i]);
            do_reset(1'b0);
        end

        // Load while busy is ignored
        table_frame(tbl[0]);
        run_frame(tbl[0], 1'b0, 40, -1, 1'b0, tbl[0]);
        do_reset(1'b0);

        // Load in the done cycle: next start bit follows at once
        table_frame(tbl[0]);
        run_frame(tbl[0], 1'b0, -1, -1, 1'b1, tbl[1]);
        table_frame(tbl[1]);
        run_frame(tbl[1], 1'b1, -1, -1, 1'b0, tbl[1]);
        do_reset(1'b0);

        // Reset (rst, then clr) during data bit 2: abort, no done, clean restart
        for (int k = 0; k < 2; k++) begin
            table_frame(tbl[0]);
            run_frame(tbl[0], 1'b0, -1, 3 * CLKDIV + 5, 1'b0, tbl[0]);
            do_reset(k == 1);
            check("abort_txd", 32'(bus.txd), 32'd1);
            check("abort_empty", 32'(bus.empty), 32'd1);
            check("abort_state", 32'(bus.state), 32'(IDLE));
            seen_done = 0;
            brg_clken = 1'b1;
            for (int c = 0; c < 3 * CLKDIV; c++) begin
                @(posedge clk); #1;
                if (bus.done === 1'b1) seen_done++;
            end
            brg_clken = 1'b0;
            check("abort_no_done", 32'(seen_done), 32'd0);
            table_frame(tbl[3]);
            run_frame(tbl[3], 1'b0, -1, -1, 1'b0, tbl[3]);
        end

        // Randomized frames against the model
        for (int r = 0; r < 16; r++) begin
            rv.data   = 8'($urandom);
            rv.len    = 2'($urandom_range(0, 3));
            rv.par    = 1'($urandom_range(0, 1));
            rv.odd    = 1'($urandom_range(0, 1));
            rv.stp    = 1'($urandom_range(0, 1));
            rv.period = $urandom_range(1, 3);
            rv.nbits  = 0;
            rv.bits   = 12'd0;
            build_frame(rv.data, rv.len, rv.par, rv.odd, rv.stp);
            run_frame(rv, 1'b0, $urandom_range(2, 60), -1, 1'b0, rv);
            do_reset(1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
